// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage directly upstream of a combinational IMEM.
//   Owns the PC register, presents it to IMEM, and captures
//   {pc, pc+4, instruction} into the IF/ID pipeline register.
//   Decode/hazard stalls hold the stage; EX-stage redirects
//   (jal/jalr/taken branch) reload the PC and flush the single IF/ID slot.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When defined, a redirect whose target has bit 1 set raises a sticky
//   misalign trap and freezes fetch until reset. When undefined, the two
//   low target bits are forced to zero and the trap ports are absent.
//
// Parameters
//   RESET_PC       PC loaded on reset.
//   NOP_INSTR      Bubble word placed in IF/ID on reset and flush.
//
// Ports
//   clk            Rising-edge clock.
//   rst            Asynchronous, active-high reset.
//   stall_i        Hold PC and IF/ID contents this cycle.
//   redirect_i     Load redirect_pc_i into the PC and flush IF/ID.
//   redirect_pc_i  Redirect target byte address.
//   imem_pc_o      Byte address to IMEM (the PC register).
//   imem_instr_i   Instruction word returned by IMEM.
//   ifid_pc_o      PC of the captured instruction.
//   ifid_pc4_o     ifid_pc_o + 4 (link value).
//   ifid_instr_o   Captured instruction.
//   ifid_valid_o   IF/ID slot holds a real instruction.
//   misalign_o     Sticky misaligned-redirect flag (macro only).
//   misalign_pc_o  Offending redirect target (macro only).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        ifid_valid_o,
    output logic        misalign_o,
    output logic [31:0] misalign_pc_o
`else
    output logic        ifid_valid_o
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic [31:0] misalign_pc_q, misalign_pc_d;

    assign target = {redirect_pc_i[31:1], 1'b0};
`else
    assign target = {redirect_pc_i[31:2], 2'b00};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
            misalign_pc_q <= misalign_pc_d;
`endif
        end
    end

    // Priority in RUN: redirect > stall > advance. A flush keeps the old
    // pc/pc4 fields; only valid and the instruction word are bubbled.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
        misalign_pc_d = misalign_pc_q;
`endif
        case (state_q)
            BOOT: begin
                // PC held one cycle so IMEM output settles; EX cannot
                // hold a valid redirect yet, so it is dropped.
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_pc_i[1]) begin
                        misalign_d    = 1'b1;
                        misalign_pc_d = target;
                        state_d       = HALT;
                    end else begin
                        pc_d = target;
                    end
`else
                    pc_d = target;
`endif
                end else if (!stall_i) begin
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = pc_plus4;
                    ifid_instr_d = imem_instr_i;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT: begin
                // Frozen until reset; IF/ID already holds the bubble.
                state_d = HALT;
            end
`endif
            default: state_d = BOOT;
        endcase
    end

    assign imem_pc_o    = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
    assign misalign_pc_o = misalign_pc_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage: boot sequence, sequential fetch, stall,
//   redirect, redirect-over-stall, PC wrap, misaligned redirect, redirect
//   during BOOT and asynchronous reset mid-operation.
//   IMEM word at address a is {8'hA5, a[23:2], 2'b11}.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
    logic [31:0] misalign_pc_o;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
`ifdef FETCH_MISALIGN_TRAP_EN
        .ifid_valid_o  (ifid_valid_o),
        .misalign_o    (misalign_o),
        .misalign_pc_o (misalign_pc_o)
`else
        .ifid_valid_o  (ifid_valid_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational IMEM model.
    always_comb imem_instr_i = {8'hA5, imem_pc_o[23:2], 2'b11};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [31:0] instr, input logic valid, input logic [31:0] ipc);
        chk({tag, ".ifid_pc"},    ifid_pc_o,    pc);
        chk({tag, ".ifid_pc4"},   ifid_pc4_o,   pc4);
        chk({tag, ".ifid_instr"}, ifid_instr_o, instr);
        chk({tag, ".ifid_valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
        chk({tag, ".imem_pc"},    imem_pc_o,    ipc);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        repeat (2) edge_step();
        chk_if("reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        rst = 1'b0;

        // Boot and sequential fetch
        edge_step(); chk_if("boot",  32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        edge_step(); chk_if("seq0",  32'h0, 32'h4, 32'hA500_0003, 1'b1, 32'h4);
        edge_step(); chk_if("seq4",  32'h4, 32'h8, 32'hA500_0007, 1'b1, 32'h8);
        edge_step(); chk_if("seq8",  32'h8, 32'hC, 32'hA500_000B, 1'b1, 32'hC);

        // Stall three cycles
        stall_i = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            edge_step(); chk_if("stall", 32'h8, 32'hC, 32'hA500_000B, 1'b1, 32'hC);
        end
        stall_i = 1'b0;
        edge_step(); chk_if("resC",  32'hC,  32'h10, 32'hA500_000F, 1'b1, 32'h10);
        edge_step(); chk_if("res10", 32'h10, 32'h14, 32'hA500_0013, 1'b1, 32'h14);
        edge_step(); chk_if("res14", 32'h14, 32'h18, 32'hA500_0017, 1'b1, 32'h18);
        edge_step(); chk_if("res18", 32'h18, 32'h1C, 32'hA500_001B, 1'b1, 32'h1C);

        // Redirect to 0x24 while imem_pc=0x1C
        redirect_i = 1'b1; redirect_pc_i = 32'h24;
        edge_step(); chk_if("redir",  32'h18, 32'h1C, 32'h0000_0013, 1'b0, 32'h24);
        redirect_i = 1'b0;
        edge_step(); chk_if("redir1", 32'h24, 32'h28, 32'hA500_0027, 1'b1, 32'h28);

        // Redirect beats simultaneous stall
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        edge_step(); chk_if("rdst",  32'h24, 32'h28, 32'h0000_0013, 1'b0, 32'h40);
        redirect_i = 1'b0; stall_i = 1'b0;
        edge_step(); chk_if("rdst1", 32'h40, 32'h44, 32'hA500_0043, 1'b1, 32'h44);

        // PC wrap at the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        edge_step(); chk_if("wrapr", 32'h40, 32'h44, 32'h0000_0013, 1'b0, 32'hFFFF_FFFC);
        redirect_i = 1'b0;
        edge_step(); chk_if("wrap",  32'hFFFF_FFFC, 32'h0, 32'hA5FF_FFFF, 1'b1, 32'h0);

        // Misaligned redirect target 0x26
        redirect_i = 1'b1; redirect_pc_i = 32'h26;
`ifdef FETCH_MISALIGN_TRAP_EN
        edge_step(); chk_if("mis", 32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        chk("mis.flag", {31'd0, misalign_o}, 32'h1);
        chk("mis.pc",   misalign_pc_o, 32'h26);
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        edge_step(); chk_if("halt", 32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        redirect_i = 1'b0;
        edge_step(); chk_if("halt2", 32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        chk("halt.flag", {31'd0, misalign_o}, 32'h1);
`else
        edge_step(); chk_if("mis",  32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 1'b0, 32'h24);
        redirect_i = 1'b0;
        edge_step(); chk_if("mis1", 32'h24, 32'h28, 32'hA500_0027, 1'b1, 32'h28);
`endif

        // Asynchronous reset mid-cycle, with a redirect pending
        redirect_i = 1'b1; redirect_pc_i = 32'h80;
        #2 rst = 1'b1;
        #1;
        chk_if("arst", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("arst.flag", {31'd0, misalign_o}, 32'h0);
        chk("arst.mpc",  misalign_pc_o, 32'h0);
`endif
        edge_step();
        rst = 1'b0;
        // Redirect and stall held during BOOT are ignored
        stall_i = 1'b1;
        edge_step(); chk_if("bootrd", 32'h0, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
        redirect_i = 1'b0; stall_i = 1'b0;
        edge_step(); chk_if("boot0",  32'h0, 32'h4, 32'hA500_0003, 1'b1, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
